// File: rtl/keypad_scanner.sv
// keypad_scanner: row-at-a-time matrix keypad scanner with a 2-flop column
// synchroniser, press/release debounce, encoded key output, a one-cycle
// valid strobe, a held level and a multi-key pulse.
module keypad_scanner #(
  parameter int unsigned NROWS    = 4,
  parameter int unsigned NCOLS    = 4,
  parameter int unsigned SCAN_DIV = 4,
  parameter int unsigned DEBOUNCE = 8,
  parameter int unsigned CODE_W   = $clog2(NROWS * NCOLS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NCOLS-1:0]  cols,
  output logic [NROWS-1:0]  rows,
  output logic [CODE_W-1:0] key_code,
  output logic              key_valid,
  output logic              held,
  output logic              multi
);

  localparam int unsigned RW      = $clog2(NROWS);
  localparam int unsigned CW      = $clog2(NCOLS);
  localparam int unsigned CNT_MAX = (SCAN_DIV > DEBOUNCE) ? SCAN_DIV : DEBOUNCE;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] DB_LAST    = CNT_W'(DEBOUNCE - 1);
  localparam logic [CNT_W-1:0] CNT_SAT    = CNT_W'(CNT_MAX);
  localparam logic [RW-1:0]    ROW_LAST   = RW'(NROWS - 1);

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    PRESS_DB = 2'd1,
    HELD     = 2'd2,
    REL_DB   = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [NCOLS-1:0]  sync1;
  logic [NCOLS-1:0]  cols_s;

  logic [RW-1:0]     row_q, row_d;
  logic [CW-1:0]     col_q, col_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CODE_W-1:0] code_d;
  logic              valid_d;
  logic              multi_d;

  logic              col_any;
  logic              col_many;
  logic [CW-1:0]     col_idx;
  logic [RW-1:0]     row_next;
  logic [CNT_W-1:0]  cnt_inc;
  logic              key_sense;

  // Two-flop synchroniser for the asynchronous column lines
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1  <= '0;
      cols_s <= '0;
    end else begin
      sync1  <= cols;
      cols_s <= sync1;
    end
  end

  // Classify the synchronised columns: none, exactly one (with index), or several
  always_comb begin
    col_any  = 1'b0;
    col_many = 1'b0;
    col_idx  = '0;
    for (int unsigned i = 0; i < NCOLS; i++) begin
      if (cols_s[i]) begin
        if (col_any) begin
          col_many = 1'b1;
        end
        col_any = 1'b1;
        col_idx = CW'(i);
      end
    end
  end

  // Helper values: wrapped next row, saturating counter increment, candidate column level
  always_comb begin
    row_next  = (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
    cnt_inc   = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CNT_W'(1);
    key_sense = cols_s[col_q];
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= SCAN;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and next-datapath logic
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    cnt_d   = cnt_q;
    code_d  = key_code;
    valid_d = 1'b0;
    multi_d = 1'b0;
    unique case (state_q)
      SCAN: begin
        if (cnt_q == DWELL_LAST) begin
          cnt_d = '0;
          if (col_any && !col_many) begin
            // Single key on this row: freeze the row and debounce that column
            col_d   = col_idx;
            state_d = PRESS_DB;
          end else begin
            row_d   = row_next;
            multi_d = col_many;
          end
        end else begin
          cnt_d = cnt_inc;
        end
      end
      PRESS_DB: begin
        if (!key_sense) begin
          state_d = SCAN;
          row_d   = row_next;
          cnt_d   = '0;
        end else if (cnt_q == DB_LAST) begin
          state_d = HELD;
          cnt_d   = '0;
          code_d  = CODE_W'(32'(row_q) * NCOLS + 32'(col_q));
          valid_d = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      HELD: begin
        if (!key_sense) begin
          state_d = REL_DB;
          cnt_d   = '0;
        end
      end
      REL_DB: begin
        if (key_sense) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_q == DB_LAST) begin
          state_d = SCAN;
          row_d   = row_next;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = SCAN;
        cnt_d   = '0;
      end
    endcase
  end

  // Datapath registers: row index, captured column, counter and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row_q     <= '0;
      col_q     <= '0;
      cnt_q     <= '0;
      key_code  <= '0;
      key_valid <= 1'b0;
      multi     <= 1'b0;
    end else begin
      row_q     <= row_d;
      col_q     <= col_d;
      cnt_q     <= cnt_d;
      key_code  <= code_d;
      key_valid <= valid_d;
      multi     <= multi_d;
    end
  end

  // Row drive and held level decoded from registered state
  always_comb begin
    rows        = '0;
    rows[row_q] = 1'b1;
    held        = (state_q == HELD) || (state_q == REL_DB);
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed-plus-random bench; expected timing is derived
// arithmetically from the scan schedule (row period, evaluation cycle,
// synchroniser and debounce delays).
module tb_keypad_scanner;

  localparam int NR = 4;
  localparam int NC = 4;
  localparam int SD = 4;
  localparam int DB = 8;
  localparam int CODEW = $clog2(NR * NC);

  logic             clk;
  logic             reset;
  logic [NC-1:0]    cols;
  logic [NR-1:0]    rows;
  logic [CODEW-1:0] key_code;
  logic             key_valid;
  logic             held;
  logic             multi;

  logic keymat [NR][NC];

  int n;
  int ncmp;
  int nfail;

  keypad_scanner #(
    .NROWS(NR),
    .NCOLS(NC),
    .SCAN_DIV(SD),
    .DEBOUNCE(DB)
  ) dut (
    .clk(clk),
    .reset(reset),
    .cols(cols),
    .rows(rows),
    .key_code(key_code),
    .key_valid(key_valid),
    .held(held),
    .multi(multi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Keypad model: a closed key connects its driven row to its column
  always_comb begin
    cols = '0;
    for (int r = 0; r < NR; r++)
      for (int c = 0; c < NC; c++)
        if (rows[r] && keymat[r][c]) cols[c] = 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s at n=%0d: observed %0h expected %0h", tag, n, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    n++;
  endtask

  function automatic logic [NR-1:0] onehot(input int r);
    logic [NR-1:0] v;
    v = '0;
    v[r] = 1'b1;
    return v;
  endfunction

  // Row driven while scanning freely, starting row base_r at cycle base_n
  function automatic logic [NR-1:0] scan_row(input int base_n, input int base_r, input int nn);
    return onehot((base_r + (nn - base_n) / SD) % NR);
  endfunction

  // First evaluation cycle of row r whose sampled columns see a press made at cycle p
  function automatic int first_eval(input int p, input int r);
    int e;
    e = p + 2;
    while (e % (NR * SD) != r * SD + SD - 1) e++;
    return e;
  endfunction

  task automatic chk_cycle(input logic [NR-1:0] er, input logic ekv, input logic eh, input logic em);
    check("rows", 32'(rows), 32'(er));
    check("key_valid", 32'(key_valid), 32'(ekv));
    check("held", 32'(held), 32'(eh));
    check("multi", 32'(multi), 32'(em));
  endtask

  task automatic clear_keys();
    for (int r = 0; r < NR; r++)
      for (int c = 0; c < NC; c++)
        keymat[r][c] = 1'b0;
  endtask

  task automatic do_reset();
    clear_keys();
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check("rst_rows", 32'(rows), 32'(onehot(0)));
    check("rst_code", 32'(key_code), 32'd0);
    check("rst_held", 32'(held), 32'd0);
    step();
    step();
    reset = 1'b0;
    n = 0;
  endtask

  // Press key (r,c) at cycle p and keep it down until h cycles after acceptance
  task automatic press_hold(input int r, input int c, input int p, input int h, output int kv);
    int e;
    while (n < p) begin
      chk_cycle(scan_row(0, 0, n), 1'b0, 1'b0, 1'b0);
      step();
    end
    keymat[r][c] = 1'b1;
    e  = first_eval(p, r);
    kv = e + DB + 1;
    while (n <= kv + h) begin
      chk_cycle((n <= e) ? scan_row(0, 0, n) : onehot(r), n == kv, n >= kv, 1'b0);
      if (n >= kv) check("key_code", 32'(key_code), 32'(r * NC + c));
      step();
    end
  endtask

  // Release the held key and follow the release debounce back into scanning
  task automatic release_key(input int r, input int c);
    int s;
    keymat[r][c] = 1'b0;
    s = n + 3 + DB;
    while (n <= s + 2 * SD) begin
      chk_cycle((n < s) ? onehot(r) : scan_row(s, (r + 1) % NR, n), 1'b0, n < s, 1'b0);
      step();
    end
    check("code_kept", 32'(key_code), 32'(r * NC + c));
  endtask

  initial begin
    int r, c, c2, p, h, kv, q, b, k, f, s, e, len;
    ncmp  = 0;
    nfail = 0;
    n     = 0;
    clear_keys();

    // Reset and idle scan
    reset = 1'b1;
    #12;
    check("rst_rows", 32'(rows), 32'(onehot(0)));
    check("rst_valid", 32'(key_valid), 32'd0);
    check("rst_held", 32'(held), 32'd0);
    check("rst_multi", 32'(multi), 32'd0);
    check("rst_code", 32'(key_code), 32'd0);
    #10;
    reset = 1'b0;
    n = 0;
    while (n < 3 * NR * SD) begin
      chk_cycle(scan_row(0, 0, n), 1'b0, 1'b0, 1'b0);
      step();
    end

    // Clean press: directed row 2 / col 1, then random keys
    for (int t = 0; t < 5; t++) begin
      do_reset();
      if (t == 0) begin
        r = 2; c = 1; p = 5; h = 4;
      end else begin
        r = $urandom_range(0, NR - 1);
        c = $urandom_range(0, NC - 1);
        p = $urandom_range(0, 20);
        h = $urandom_range(0, 10);
      end
      press_hold(r, c, p, h, kv);
      release_key(r, c);
    end

    // Press bounce on row 0 / col 3, longest rejected length first
    for (int t = 0; t < 4; t++) begin
      do_reset();
      len = (t == 0) ? DB : $urandom_range(1, DB);
      p = NR * SD + 1;
      e = first_eval(p, 0);
      s = p + len + 3;
      while (n <= s + 2 * SD) begin
        keymat[0][3] = (n >= p) && (n < p + len);
        chk_cycle((n <= e) ? scan_row(0, 0, n) : ((n < s) ? onehot(0) : scan_row(s, 1, n)),
                  1'b0, 1'b0, 1'b0);
        step();
      end
      check("bounce_code", 32'(key_code), 32'd0);
    end

    // Release bounce: gap of up to DEBOUNCE cycles keeps the key held
    for (int t = 0; t < 4; t++) begin
      do_reset();
      r = $urandom_range(0, NR - 1);
      c = $urandom_range(0, NC - 1);
      press_hold(r, c, $urandom_range(0, 10), $urandom_range(0, 5), kv);
      q = n;
      b = (t == 0) ? DB : $urandom_range(1, DB);
      k = $urandom_range(1, 6);
      f = q + b + k;
      s = f + 3 + DB;
      while (n <= s + SD) begin
        keymat[r][c] = (n >= q + b) && (n < f);
        chk_cycle((n < s) ? onehot(r) : scan_row(s, (r + 1) % NR, n), 1'b0, n < s, 1'b0);
        step();
      end
      check("relb_code", 32'(key_code), 32'(r * NC + c));
    end

    // Multi-key: two columns on one row, directed row 1 cols 0/3 then random
    for (int t = 0; t < 3; t++) begin
      do_reset();
      if (t == 0) begin
        r = 1; c = 0; c2 = 3;
      end else begin
        r  = $urandom_range(0, NR - 1);
        c  = $urandom_range(0, NC - 1);
        c2 = (c + $urandom_range(1, NC - 1)) % NC;
      end
      keymat[r][c]  = 1'b1;
      keymat[r][c2] = 1'b1;
      while (n < 3 * NR * SD) begin
        chk_cycle(scan_row(0, 0, n), 1'b0, 1'b0,
                  (n >= 1) && ((n - 1) % (NR * SD) == r * SD + SD - 1));
        step();
      end
      check("multi_code", 32'(key_code), 32'd0);
      clear_keys();
    end

    // Asynchronous reset while a key is held
    do_reset();
    r = $urandom_range(0, NR - 1);
    c = $urandom_range(1, NC - 1);
    press_hold(r, c, $urandom_range(0, 10), 2, kv);
    #2;
    reset = 1'b1;
    #1;
    check("async_held", 32'(held), 32'd0);
    check("async_code", 32'(key_code), 32'd0);
    check("async_rows", 32'(rows), 32'(onehot(0)));
    check("async_valid", 32'(key_valid), 32'd0);
    clear_keys();
    step();
    step();
    reset = 1'b0;
    n = 0;
    while (n < 2 * NR * SD) begin
      chk_cycle(scan_row(0, 0, n), 1'b0, 1'b0, 1'b0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Parametrised matrix-keypad scanner replacing the fixed 4x4 keypad input stage. Drives one row at a time, samples the synchronised column lines, debounces both press and release, and reports a single encoded key with a one-cycle valid strobe, a held level and a multi-key flag. It sits between the FPGA keypad pins and the digit/display logic.

## Interface
- NROWS, 4, number of row lines driven (>= 2)
- NCOLS, 4, number of column lines sensed (>= 2)
- SCAN_DIV, 4, cycles each row is driven while scanning (>= 3, covers synchroniser latency)
- DEBOUNCE, 8, consecutive stable cycles needed to accept a press or a release (>= 1)
- CODE_W, $clog2(NROWS*NCOLS), key code width (derived, do not override)

- clk  in  1  system clock; one clock domain only
- reset  in  1  asynchronous, active-high reset
- cols  in  NCOLS  raw column sense lines, active-high, asynchronous to clk
- rows  out  NROWS  row drive, one-hot active-high
- key_code  out  CODE_W  row*NCOLS + col of the last accepted key
- key_valid  out  1  one-cycle pulse when a press is accepted
- held  out  1  high while the accepted key is still down
- multi  out  1  one-cycle pulse when a scanned row shows more than one column high

## Operation
- cols pass through a 2-flop synchroniser (colsS). Only colsS is used internally.
- State register: SCAN, PRESS_DB, HELD, REL_DB. Row index r (0..NROWS-1) and captured column c are registered.
- SCAN: rows = one-hot(r). A dwell counter counts 0..SCAN_DIV-1. On the last dwell cycle, colsS is evaluated:
  - colsS all zero: r advances, wrapping NROWS-1 -> 0; dwell restarts.
  - exactly one bit set: capture c, go to PRESS_DB. r is frozen, so rows stay at the same value.
  - two or more bits set: pulse multi, then advance r as in the zero case.
- PRESS_DB: a counter counts consecutive cycles with colsS[c]=1.
  - Reaching DEBOUNCE goes to HELD, registers key_code = r*NCOLS+c and pulses key_valid.
  - colsS[c]=0 before that drops the candidate. Go to SCAN with r advanced. No output changes.
- HELD: held=1 and rows stay frozen. Other columns are ignored, with no rollover and no multi. colsS[c]=0 goes to REL_DB with the counter cleared.
- REL_DB: counts consecutive cycles with colsS[c]=0.
  - colsS[c]=1 returns to HELD. No new key_valid.
  - Reaching DEBOUNCE goes to SCAN with r advanced and held cleared.
- key_code holds its value until the next accepted press. It is not cleared on release.
- Counters saturate and never wrap. Width is clog2(max(SCAN_DIV, DEBOUNCE)+1).

## Timing
- Reset (asynchronous, immediate) forces: state SCAN, r=0, rows=one-hot(0), key_code=0, key_valid=0, held=0, multi=0, all counters and synchroniser flops 0.
- Scan period is NROWS*SCAN_DIV cycles. After reset deasserts, the row changes every SCAN_DIV cycles.
- Input-to-state latency is 2 cycles (synchroniser).
- key_valid and held rise in the same cycle, the first cycle in HELD. key_valid is high for exactly 1 cycle.
- Press acceptance, counted from the evaluation cycle, takes DEBOUNCE+1 cycles to reach key_valid.
- held falls on the first SCAN cycle after REL_DB completes. rows advance on that same cycle.
- multi is a 1-cycle pulse in the cycle after the evaluation.
- Reset asserted mid-debounce or mid-HELD aborts the operation. No key_valid is emitted. After reset, scanning restarts at row 0.

## Test plan
All scenarios use NROWS=4, NCOLS=4, SCAN_DIV=4, DEBOUNCE=8. The bench models a key by returning cols bit c high while rows bit r is high.
- Reset and idle:
  - Stimulus: reset=1 for 22 ns, then released with no key.
  - Required: rows=0001 with all outputs 0 during reset. After release, rows cycle 0001->0010->0100->1000->0001, each for 4 cycles.
- Clean press of row 2, col 1:
  - Required: key_valid is a single pulse with key_code=9. held=1 and rows stay 0100 while the key is down.
  - Then release the key. Required: held=0 exactly 8+ cycles after the release is seen, and the scan resumes at rows=1000.
- Press bounce:
  - Stimulus: on row 0, col 3 is high for 5 cycles then low.
  - Required: no key_valid and key_code unchanged. Scanning resumes at rows=0010.
- Release bounce:
  - Stimulus: in HELD, the column goes low for 3 cycles, high again, then low for 10 cycles.
  - Required: held stays 1 through the bounce and only one key_valid in total. held=0 after the final release.
- Multi-key:
  - Stimulus: row 1 with cols 0 and 3 both high.
  - Required: a multi pulse each time row 1 is evaluated, no key_valid, and rows keep rotating.
- Async reset mid-HELD:
  - Stimulus: reset asserted between clock edges.
  - Required: held=0, key_code=0 and rows=0001 immediately, without waiting for a clk edge.
